// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, DATA_BITS data bits (LSB first), optional parity, stop.
// The data-bit index lives in an external loadable down counter driven through cnt_load/cnt_down.
module uart_tx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PAR_EN       = 1'b1,
    parameter bit PAR_ODD      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic                 cnt_load,
    output logic                 cnt_down,
    output logic                 cnt_up,
    output logic [3:0]           cnt_in,
    input  logic                 cnt_low
);

    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [PW-1:0]          psc_r, psc_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic                   par_r, par_s;
    logic                   bit_end_s;
    logic                   serial_r, serial_s;
    logic                   ready_r, ready_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   load_r, load_s;
    logic                   down_r, down_s;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    assign tx_ready   = ready_r;
    assign tx_serial  = serial_r;
    assign tx_busy    = busy_r;
    assign frame_done = done_r;
    assign cnt_load   = load_r;
    assign cnt_down   = down_r;
    assign cnt_up     = 1'b0;
    assign cnt_in     = 4'(DATA_BITS - 1);

    // Next-state, datapath and next-output decode
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        par_s     = par_r;
        psc_s     = psc_r;
        bit_end_s = (psc_r == PSC_MAX);

        case (state_r)
            S_IDLE: begin
                if (tx_valid && ready_r) begin
                    state_s = S_START;
                    shift_s = tx_data;
                    par_s   = calc_parity(tx_data);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) state_s = S_DATA;
                else           state_s = S_START;
            end
            S_DATA: begin
                if (bit_end_s && cnt_low) begin
                    state_s = PAR_EN ? S_PARITY : S_STOP;
                end else if (bit_end_s) begin
                    shift_s = shift_r >> 1;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) state_s = S_STOP;
                else           state_s = S_PARITY;
            end
            S_STOP: begin
                if (bit_end_s) state_s = S_IDLE;
                else           state_s = S_STOP;
            end
            default: state_s = S_IDLE;
        endcase

        // Prescaler restarts on every bit boundary and stays parked at 0 in IDLE
        if ((state_r == S_IDLE) || bit_end_s || (state_s != state_r)) begin
            psc_s = '0;
        end else begin
            psc_s = psc_r + PW'(1);
        end

        case (state_s)
            S_START:  serial_s = 1'b0;
            S_DATA:   serial_s = shift_s[0];
            S_PARITY: serial_s = par_s;
            default:  serial_s = 1'b1;
        endcase

        // Strobes are registered, so they are decoded from the upcoming state/prescaler.
        // cnt_low is stable across a bit period, so sampling it one cycle early is exact.
        ready_s = (state_s == S_IDLE);
        busy_s  = (state_s != S_IDLE);
        load_s  = (state_s == S_START) && (psc_s == PSC_MAX);
        down_s  = (state_s == S_DATA)  && (psc_s == PSC_MAX) && !cnt_low;
        done_s  = (state_s == S_STOP)  && (psc_s == PSC_MAX);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            psc_r    <= '0;
            shift_r  <= '0;
            par_r    <= 1'b0;
            serial_r <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            load_r   <= 1'b0;
            down_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            psc_r    <= psc_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            serial_r <= serial_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            load_r   <= load_s;
            down_r   <= down_s;
        end
    end

endmodule
